destroyable_block: RTL

- Game-logic stage that drives the display controller's blockPos/blockVisible inputs and the level's solidity view of one breakable block.
- Runs on sim_clk and consumes blade and player positions.
- Counts blade hits, plays a flashing break animation, then hides the block. After a timeout it respawns the block, but only once the player is clear of the block footprint.

---
 rtl/sk_pkg.sv | 25 ++
 rtl/aabb_overlap.sv | 34 +++
 rtl/destroyable_block.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sk_pkg.sv
// Shared game-logic definitions: FSM state encoding, sprite sizes and the
// packed {x, y} position layout used by the display controller.
package sk_pkg;

  localparam int POS_W       = 10;
  localparam int BLOCK_POS_W = 2 * POS_W;
  localparam int TILE_SIZE   = 32;

  localparam int SPRITE_PLAYER_W = 32;
  localparam int SPRITE_PLAYER_H = 32;
  localparam int SPRITE_BLADE_W  = 16;
  localparam int SPRITE_BLADE_H  = 16;

  localparam logic [1:0] STATE_INTACT       = 2'd0;
  localparam logic [1:0] STATE_BREAKING     = 2'd1;
  localparam logic [1:0] STATE_GONE         = 2'd2;
  localparam logic [1:0] STATE_RESPAWN_WAIT = 2'd3;

  typedef logic [POS_W-1:0] pos_t;

  function automatic logic [BLOCK_POS_W-1:0] packPos(input pos_t x, input pos_t y);
    return {x, y};
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned box overlap test between box A and box B.
// Edges that merely touch do not count as overlapping.
module aabb_overlap
  import sk_pkg::*;
#(
  parameter int A_W = 16,
  parameter int A_H = 16,
  parameter int B_W = 32,
  parameter int B_H = 32
) (
  input  logic [POS_W-1:0] aX,
  input  logic [POS_W-1:0] aY,
  input  logic [POS_W-1:0] bX,
  input  logic [POS_W-1:0] bY,
  output logic             overlap
);

  // One extra bit so that position + size never wraps.
  logic [POS_W:0] aXw, aYw, bXw, bYw;
  logic [POS_W:0] aXEnd, aYEnd, bXEnd, bYEnd;

  assign aXw   = {1'b0, aX};
  assign aYw   = {1'b0, aY};
  assign bXw   = {1'b0, bX};
  assign bYw   = {1'b0, bY};
  assign aXEnd = aXw + (POS_W+1)'(A_W);
  assign aYEnd = aYw + (POS_W+1)'(A_H);
  assign bXEnd = bXw + (POS_W+1)'(B_W);
  assign bYEnd = bYw + (POS_W+1)'(B_H);

  assign overlap = (aXw < bXEnd) && (bXw < aXEnd) &&
                   (aYw < bYEnd) && (bYw < aYEnd);

endmodule

// File: rtl/destroyable_block.sv
// Breakable block: counts blade hits, flashes while breaking, hides, and
// respawns after a timeout once the player has left the block footprint.
module destroyable_block
  import sk_pkg::*;
#(
  parameter int BLOCK_X       = 300,
  parameter int BLOCK_Y       = 200,
  parameter int BLOCK_W       = TILE_SIZE,
  parameter int BLOCK_H       = TILE_SIZE,
  parameter int BLADE_W       = SPRITE_BLADE_W,
  parameter int BLADE_H       = SPRITE_BLADE_H,
  parameter int PLAYER_W      = SPRITE_PLAYER_W,
  parameter int PLAYER_H      = SPRITE_PLAYER_H,
  parameter int MAX_HP        = 3,
  parameter int BREAK_TICKS   = 30,
  parameter int RESPAWN_TICKS = 180,
  parameter int TIMER_W       = 8,
  parameter int FLASH_BIT     = 2
) (
  input  logic                   sim_clk,
  input  logic                   reset_n,
  input  logic                   blade_active,
  input  logic [POS_W-1:0]       blade_xPos,
  input  logic [POS_W-1:0]       blade_yPos,
  input  logic [POS_W-1:0]       player_xPos,
  input  logic [POS_W-1:0]       player_yPos,
  output logic [BLOCK_POS_W-1:0] blockPos,
  output logic                   blockVisible,
  output logic                   blockSolid,
  output logic                   hitPulse,
  output logic [2:0]             blockHp,
  output logic [1:0]             dbgState
);

  localparam logic [POS_W-1:0]   BLOCK_X_P  = POS_W'(BLOCK_X);
  localparam logic [POS_W-1:0]   BLOCK_Y_P  = POS_W'(BLOCK_Y);
  localparam logic [2:0]         HP_INIT    = 3'(MAX_HP);
  localparam logic [TIMER_W-1:0] BREAK_END  = TIMER_W'(BREAK_TICKS - 1);
  localparam logic [TIMER_W-1:0] RESPAWN_END = TIMER_W'(RESPAWN_TICKS - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  logic [1:0]         state, stateNext;
  logic [TIMER_W-1:0] timer, timerNext;
  logic [2:0]         hpNext;
  logic               pulseNext;
  logic               visibleNext, solidNext;
  logic               bladeHitsBox, playerOvl;
  logic               bladeOvl, bladeOvl_q, hitEvent;

  assign blockPos = packPos(BLOCK_X_P, BLOCK_Y_P);
  assign dbgState = state;

  aabb_overlap #(
    .A_W(BLADE_W), .A_H(BLADE_H), .B_W(BLOCK_W), .B_H(BLOCK_H)
  ) u_bladeOvl (
    .aX(blade_xPos), .aY(blade_yPos), .bX(BLOCK_X_P), .bY(BLOCK_Y_P),
    .overlap(bladeHitsBox)
  );

  aabb_overlap #(
    .A_W(PLAYER_W), .A_H(PLAYER_H), .B_W(BLOCK_W), .B_H(BLOCK_H)
  ) u_playerOvl (
    .aX(player_xPos), .aY(player_yPos), .bX(BLOCK_X_P), .bY(BLOCK_Y_P),
    .overlap(playerOvl)
  );

  // Rising edge of contact: a blade resting inside the block counts once.
  assign bladeOvl = blade_active & bladeHitsBox;
  assign hitEvent = bladeOvl & ~bladeOvl_q;

  always_comb begin
    stateNext = state;
    timerNext = timer;
    hpNext    = blockHp;
    pulseNext = 1'b0;
    case (state)
      STATE_INTACT: begin
        if (hitEvent) begin
          pulseNext = 1'b1;
          if (blockHp > 3'd1) begin
            hpNext = blockHp - 3'd1;
          end else begin
            hpNext    = 3'd0;
            timerNext = '0;
            stateNext = STATE_BREAKING;
          end
        end
      end
      STATE_BREAKING: begin
        if (timer == BREAK_END) begin
          timerNext = '0;
          stateNext = STATE_GONE;
        end else begin
          timerNext = timer + TIMER_ONE;
        end
      end
      STATE_GONE: begin
        if (timer == RESPAWN_END) begin
          timerNext = '0;
          stateNext = STATE_RESPAWN_WAIT;
        end else begin
          timerNext = timer + TIMER_ONE;
        end
      end
      default: begin
        if (!playerOvl) begin
          hpNext    = HP_INIT;
          stateNext = STATE_INTACT;
        end
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as it.
  always_comb begin
    solidNext   = (stateNext == STATE_INTACT);
    visibleNext = (stateNext == STATE_INTACT) ||
                  ((stateNext == STATE_BREAKING) && timerNext[FLASH_BIT]);
  end

  always_ff @(posedge sim_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= STATE_INTACT;
      timer        <= '0;
      blockHp      <= HP_INIT;
      bladeOvl_q   <= 1'b0;
      hitPulse     <= 1'b0;
      blockVisible <= 1'b1;
      blockSolid   <= 1'b1;
    end else begin
      state        <= stateNext;
      timer        <= timerNext;
      blockHp      <= hpNext;
      bladeOvl_q   <= bladeOvl;
      hitPulse     <= pulseNext;
      blockVisible <= visibleNext;
      blockSolid   <= solidNext;
    end
  end

endmodule
